feature_line_buffer: RTL and testbench
======================================

# feature_line_buffer

Ping-pong activation buffer between two dense layers. Accepts the producing layer's serial 16-bit writes (address, data, enable) and packs them into 25-word, 400-bit lines. Serves the consuming layer's segment-indexed wide reads with one-cycle latency. Sequences both layers with enable / finished handshakes so that layer N+1 reads one bank while layer N fills the other.

## Interface
Parameters:
- WORDS_PER_LINE, 25, 16-bit words per line; read width is 16*WORDS_PER_LINE.
- LINE_NUM, 4, lines per bank; bank capacity is LINE_NUM*WORDS_PER_LINE words (100).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en_in  in  1  producer write strobe.
- wr_addr_in  in  32  producer word address, linear from 0.
- wr_data_in  in  16  producer write data.
- wr_done_in  in  1  producer finished, level; held high until prod_en falls.
- prod_en  out  1  enable to producer; producer resets its counters while low.
- rd_addr_in  in  32  consumer line (segment) index.
- rd_data_out  out  16*WORDS_PER_LINE  line data; word k at bits [16k+15:16k].
- rd_done_in  in  1  consumer finished, level; held high until cons_en falls.
- cons_en  out  1  enable to consumer.
- err_ovf  out  1  sticky error flag.

## Operation
Storage and pointers:
- Two banks of LINE_NUM x 400-bit registers.
- Pointers wsel (write bank) and rsel (read bank); flags full[1:0].

Write path:
- Write accepted when wr_en_in=1, full[wsel]=0 and wr_addr_in < LINE_NUM*WORDS_PER_LINE.
- Accepted write stores to line wr_addr_in/25, slot wr_addr_in%25.
- Writes are not gated by prod_en. A write in the same cycle as the wr_done_in rising edge lands in the bank being closed.
- Rejected write (address out of range, or full[wsel]=1): data dropped, err_ovf set.

Producer done:
- Edge detect: wr_done_in=1 and registered copy=0.
- On the edge: full[wsel]<=1, wsel<=~wsel.

Consumer done:
- Edge detect on rd_done_in, same scheme.
- On the edge: the bank at rsel is zeroed (all lines), full[rsel]<=0, rsel<=~rsel.

Read path:
- rd_data_out <= bank[rsel][rd_addr_in], registered every cycle.
- rd_addr_in >= LINE_NUM returns 0.

Enables, both registered:
- prod_en <= !full_next[wsel_next] && !wr_done_in.
- cons_en <= full_next[rsel_next] && !rd_done_in.
- "next" means the values after this cycle's updates.
- Each enable is therefore low for at least one cycle after its done rises. This lets the attached layer clear its counters and drop done.

Bank states, per bank, derived from full and the pointers:
- EMPTY → FILLING: bank is at wsel.
- FILLING → FULL: producer done edge.
- FULL → READING: bank is at rsel.
- READING → EMPTY (zeroed): consumer done edge.

Simultaneous events:
- Producer done and consumer done on different banks in the same cycle: both applied.
- A write and a consumer-done zeroing in the same cycle always target different banks.

err_ovf is cleared only by reset.

## Timing
Reset state (rst_n=0, asynchronous):
- All bank contents 0; wsel=rsel=0; full=00.
- prod_en=0, cons_en=0, rd_data_out=0, err_ovf=0.
- Done-edge registers are cleared.

After reset release:
- prod_en=1 after the first clock edge.

Latencies:
- Read latency: 1 cycle, address to rd_data_out.
- Write to readable: a write at cycle t with done edge at t+d makes full set at t+d. cons_en rises at t+d+1 if the bank is at rsel. rd_data_out reflects the data one cycle after the address is presented.
- Producer done edge at t: prod_en=0 at t+1; it rises only after wr_done_in is seen low and the other bank is not full.
- Consumer done edge at t: bank zeroed at t+1; cons_en=0 at t+1. cons_en rises again once rd_done_in is low and the other bank is full.

Backpressure:
- Both banks full → prod_en stays 0 until a consumer done edge frees a bank.

Mid-operation reset:
- Reset during any fill or read aborts it immediately.
- All data is discarded and outputs take their reset values. No partial bank survives.

## Test plan
- Fill: write addresses 0..99 with data=addr+1, raise wr_done_in. Required: prod_en=0 next cycle, cons_en=1 one cycle later. rd_addr_in=2 → rd_data_out word 0 = 51, word 24 = 75, one cycle later.
- Partial line: write only address 30 = 0x1234, then done. Required: line 1 word 5 = 0x1234, all other words 0. rd_addr_in=7 → 0.
- Ping-pong: fill bank 0, then fill bank 1 while the consumer reads bank 0. Required: bank 1 data is unaffected by bank-0 reads. After rd_done_in, cons_en drops for ≥1 cycle, then reads return bank-1 data. Bank 0 reads back all zero on its next fill.
- Backpressure: fill both banks without consumer done. Required: prod_en stays 0; a write to address 3 sets err_ovf=1 and does not alter either bank.
- Overflow and simultaneous events: a write to address 100 sets err_ovf=1. Producer done and consumer done in the same cycle both take effect: full flags swap correctly, both enables low for one cycle.
- Async reset asserted mid-fill (after address 40): all outputs 0 immediately. After release, prod_en=1 and a read of line 0 returns 0.

Source files
------------

// File: rtl/feature_line_buffer_if.sv
// Producer/consumer bus of the ping-pong feature line buffer: serial word
// writes in, segment-indexed wide reads out, plus the layer handshakes.
interface feature_line_buffer_if #(
  parameter int WORDS_PER_LINE = 25
);
  logic                          wr_en_in;
  logic [31:0]                   wr_addr_in;
  logic [15:0]                   wr_data_in;
  logic                          wr_done_in;
  logic                          prod_en;
  logic [31:0]                   rd_addr_in;
  logic [16*WORDS_PER_LINE-1:0]  rd_data_out;
  logic                          rd_done_in;
  logic                          cons_en;
  logic                          err_ovf;

  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, wr_done_in,
    input  rd_addr_in, rd_done_in,
    output prod_en, rd_data_out, cons_en, err_ovf
  );

  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, wr_done_in,
    output rd_addr_in, rd_done_in,
    input  prod_en, rd_data_out, cons_en, err_ovf
  );
endinterface

// File: rtl/feature_line_buffer.sv
// Two-bank activation buffer: one layer fills a bank word by word while the
// next layer reads whole lines from the other bank, swapped on done edges.
module feature_line_buffer #(
  parameter int WORDS_PER_LINE = 25,
  parameter int LINE_NUM       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  feature_line_buffer_if.slave   bus
);

  localparam int LINE_W     = 16 * WORDS_PER_LINE;
  localparam int BANK_WORDS = LINE_NUM * WORDS_PER_LINE;

  // Flat word storage; word w of a bank belongs to line w/WORDS_PER_LINE.
  logic [15:0]           mem_q [2][BANK_WORDS];

  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_done_q, rd_done_q;
  logic                  prod_en_q, prod_en_d;
  logic                  cons_en_q, cons_en_d;
  logic                  err_q, err_d;
  logic [LINE_W-1:0]     rd_data_q, rd_data_d;

  logic                  prod_edge, cons_edge;
  logic                  wr_in_range, wr_accept, wr_reject;
  logic [BANK_WORDS-1:0] word_hit;

  assign prod_edge   = bus.wr_done_in && !wr_done_q;
  assign cons_edge   = bus.rd_done_in && !rd_done_q;
  assign wr_in_range = bus.wr_addr_in < 32'(BANK_WORDS);
  assign wr_accept   = bus.wr_en_in && wr_in_range && !full_q[wsel_q];
  assign wr_reject   = bus.wr_en_in && (!wr_in_range || full_q[wsel_q]);

  for (genvar gi = 0; gi < BANK_WORDS; gi++) begin : g_word_dec
    assign word_hit[gi] = (bus.wr_addr_in == 32'(gi));
  end

  // Pointer/flag next state: a producer done closes wsel, a consumer done
  // releases rsel; on different banks both apply in the same cycle.
  always_comb begin
    full_d = full_q;
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    if (prod_edge) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
    end
    if (cons_edge) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end
    prod_en_d = !full_d[wsel_d] && !bus.wr_done_in;
    cons_en_d = full_d[rsel_d] && !bus.rd_done_in;
    err_d     = err_q || wr_reject;
  end

  // Line mux over the read bank; an out-of-range segment index yields zero.
  always_comb begin
    rd_data_d = '0;
    for (int l = 0; l < LINE_NUM; l++) begin
      if (bus.rd_addr_in == 32'(l)) begin
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
          rd_data_d[16*k +: 16] = mem_q[rsel_q][l*WORDS_PER_LINE + k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < BANK_WORDS; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < BANK_WORDS; w++) begin
        if (wr_accept && word_hit[w]) begin
          mem_q[wsel_q][w] <= bus.wr_data_in;
        end
        // Released bank is cleared so a sparse refill reads zeros elsewhere.
        if (cons_edge) begin
          mem_q[rsel_q][w] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      full_q    <= 2'b00;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      prod_en_q <= 1'b0;
      cons_en_q <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      full_q    <= full_d;
      wr_done_q <= bus.wr_done_in;
      rd_done_q <= bus.rd_done_in;
      prod_en_q <= prod_en_d;
      cons_en_q <= cons_en_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.prod_en     = prod_en_q;
  assign bus.cons_en     = cons_en_q;
  assign bus.err_ovf     = err_q;
  assign bus.rd_data_out = rd_data_q;

endmodule

// File: tb/tb_feature_line_buffer.sv
// Directed bench for feature_line_buffer: stimulus queues expected outputs
// tagged with the cycle they must appear; a negedge monitor checks them.
module tb_feature_line_buffer;

  localparam int WPL = 25;
  localparam int LN  = 4;
  localparam int W   = 16 * WPL;

  localparam int K_RD   = 0;
  localparam int K_PROD = 1;
  localparam int K_CONS = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  exp_t sb[$];

  feature_line_buffer_if #(.WORDS_PER_LINE(WPL)) bus();

  feature_line_buffer #(
    .WORDS_PER_LINE(WPL),
    .LINE_NUM(LN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input int kind, input logic [W-1:0] v, input string nm);
    exp_t e;
    e.cyc  = cycle_cnt + d;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Line l of a sequential fill where word at address a holds a+1.
  function automatic logic [W-1:0] full_line(input int l);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < WPL; k++) r[16*k +: 16] = 16'(25*l + k + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] one_word(input int k, input logic [15:0] v);
    logic [W-1:0] r;
    r = '0;
    r[16*k +: 16] = v;
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cycle_cnt) begin
        logic [W-1:0] act;
        case (sb[i].kind)
          K_RD:    act = bus.rd_data_out;
          K_PROD:  act = W'(bus.prod_en);
          K_CONS:  act = W'(bus.cons_en);
          default: act = W'(bus.err_ovf);
        endcase
        n_checks++;
        if (sb[i].cyc < cycle_cnt) begin
          n_fail++;
          $display("FAIL %s: check missed at cycle %0d, due %0d", sb[i].name, cycle_cnt, sb[i].cyc);
        end else if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %h required %h", sb[i].name, cycle_cnt, act, sb[i].exp);
        end else begin
          $display("check %s cyc %0d ok", sb[i].name, cycle_cnt);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    bus.wr_en_in   = 1'b0;
    bus.wr_addr_in = '0;
    bus.wr_data_in = '0;
    bus.wr_done_in = 1'b0;
    bus.rd_addr_in = '0;
    bus.rd_done_in = 1'b0;
    rst_n = 1'b0;
    tick(); tick();

    // Reset state
    push_exp(0, K_RD,   '0, "rst_rd_data");
    push_exp(0, K_PROD, '0, "rst_prod_en");
    push_exp(0, K_CONS, '0, "rst_cons_en");
    push_exp(0, K_ERR,  '0, "rst_err_ovf");
    tick();
    rst_n = 1'b1;
    push_exp(1, K_PROD, 1, "prod_en_after_rst");
    push_exp(1, K_CONS, 0, "cons_en_after_rst");
    tick();

    // Full fill of bank 0; last write coincides with the done edge
    for (int a = 0; a < 100; a++) begin
      bus.wr_en_in   = 1'b1;
      bus.wr_addr_in = 32'(a);
      bus.wr_data_in = 16'(a + 1);
      if (a == 99) begin
        bus.wr_done_in = 1'b1;
        push_exp(1, K_PROD, 0, "prod_en_fill_done");
        push_exp(1, K_CONS, 1, "cons_en_fill_done");
      end else if (a == 50) begin
        push_exp(1, K_CONS, 0, "cons_en_while_fill");
      end
      tick();
    end
    bus.wr_en_in   = 1'b0;
    bus.wr_done_in = 1'b0;
    bus.rd_addr_in = 2;
    push_exp(1, K_RD,   full_line(2), "fill_line2");
    push_exp(1, K_PROD, 1, "prod_en_bank1_free");
    push_exp(1, K_ERR,  0, "err_clean_fill");
    tick();
    bus.rd_addr_in = 3;
    push_exp(1, K_RD, full_line(3), "fill_line3_done_cycle_write");
    tick();

    // Partial line into bank 1 while bank 0 is read
    bus.wr_en_in   = 1'b1;
    bus.wr_addr_in = 30;
    bus.wr_data_in = 16'h1234;
    bus.rd_addr_in = 0;
    push_exp(1, K_RD, full_line(0), "bank0_line0_during_bank1_write");
    tick();
    bus.wr_en_in   = 1'b0;
    bus.wr_done_in = 1'b1;
    push_exp(1, K_PROD, 0, "prod_en_bank1_done");
    push_exp(1, K_CONS, 1, "cons_en_hold_bank0");
    tick();

    // Backpressure: both banks full
    bus.wr_done_in = 1'b0;
    push_exp(1, K_PROD, 0, "prod_en_backpressure");
    tick();
    bus.wr_en_in   = 1'b1;
    bus.wr_addr_in = 3;
    bus.wr_data_in = 16'hDEAD;
    push_exp(1, K_ERR,  1, "err_ovf_full_write");
    push_exp(1, K_PROD, 0, "prod_en_backpressure2");
    tick();
    bus.wr_en_in = 1'b0;
    push_exp(1, K_RD, full_line(0), "bank0_line0_unaltered");
    tick();

    // Consumer done releases bank 0, reads move to bank 1
    bus.rd_done_in = 1'b1;
    push_exp(1, K_CONS, 0, "cons_en_drop");
    push_exp(1, K_PROD, 1, "prod_en_bank0_freed");
    tick();
    bus.rd_done_in = 1'b0;
    bus.rd_addr_in = 1;
    push_exp(1, K_CONS, 1, "cons_en_bank1");
    push_exp(1, K_RD,   one_word(5, 16'h1234), "partial_line1");
    tick();
    bus.rd_addr_in = 7;
    push_exp(1, K_RD, '0, "line7_out_of_range");
    tick();
    bus.rd_addr_in = 0;
    push_exp(1, K_RD, '0, "bank1_line0_untouched");
    tick();

    // Refill bank 0 sparsely, then simultaneous producer and consumer done
    bus.wr_en_in   = 1'b1;
    bus.wr_addr_in = 60;
    bus.wr_data_in = 16'hBEEF;
    tick();
    bus.wr_en_in   = 1'b0;
    bus.wr_done_in = 1'b1;
    bus.rd_done_in = 1'b1;
    push_exp(1, K_PROD, 0, "prod_en_simul");
    push_exp(1, K_CONS, 0, "cons_en_simul");
    tick();
    bus.wr_done_in = 1'b0;
    bus.rd_done_in = 1'b0;
    bus.rd_addr_in = 2;
    push_exp(1, K_PROD, 1, "prod_en_after_simul");
    push_exp(1, K_CONS, 1, "cons_en_after_simul");
    push_exp(1, K_RD,   one_word(10, 16'hBEEF), "bank0_refill_line2");
    tick();
    bus.rd_addr_in = 0;
    push_exp(1, K_RD, '0, "bank0_line0_zeroed");
    tick();

    // Reset asserted in the middle of a bank-1 fill
    bus.rd_addr_in = 2;
    for (int a = 0; a <= 40; a++) begin
      bus.wr_en_in   = 1'b1;
      bus.wr_addr_in = 32'(a);
      bus.wr_data_in = 16'(a + 1);
      tick();
    end
    bus.wr_en_in = 1'b0;
    push_exp(0, K_ERR, 1, "err_sticky_before_reset");
    push_exp(0, K_RD,  one_word(10, 16'hBEEF), "rd_before_reset");
    tick();
    rst_n = 1'b0;
    push_exp(0, K_RD,   '0, "midrst_rd_data");
    push_exp(0, K_PROD, '0, "midrst_prod_en");
    push_exp(0, K_CONS, '0, "midrst_cons_en");
    push_exp(0, K_ERR,  '0, "midrst_err_ovf");
    tick();
    rst_n = 1'b1;
    push_exp(1, K_PROD, 1, "prod_en_after_midrst");
    push_exp(1, K_CONS, 0, "cons_en_after_midrst");
    push_exp(1, K_ERR,  0, "err_after_midrst");
    tick();
    bus.wr_done_in = 1'b1;
    push_exp(1, K_CONS, 1, "cons_en_empty_bank");
    push_exp(1, K_PROD, 0, "prod_en_empty_bank_done");
    tick();
    bus.wr_done_in = 1'b0;
    bus.rd_addr_in = 0;
    push_exp(1, K_RD, '0, "line0_after_reset");
    tick();
    bus.rd_addr_in = 1;
    push_exp(1, K_RD, '0, "line1_after_reset");
    tick();
    bus.rd_addr_in = 2;
    push_exp(1, K_RD, '0, "line2_after_reset");
    tick();

    // Out-of-range write address
    bus.wr_en_in   = 1'b1;
    bus.wr_addr_in = 100;
    bus.wr_data_in = 16'h5555;
    push_exp(1, K_ERR,  1, "err_ovf_addr100");
    push_exp(1, K_PROD, 1, "prod_en_after_addr100");
    tick();
    bus.wr_en_in = 1'b0;
    repeat (3) tick();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending_expectations: got %0d left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
